ram_bubble_sort_ctrl: RTL

- In-place bubble-sort sequencer for one single-port synchronous RAM: ram_rd_data is registered, with 1-cycle read latency, and a write and a read may not target different addresses in the same cycle.
- On start, sorts entries 0..len-1 ascending (unsigned), then pulses done.
- Sits between the top-level control and the RAM instance; it is the RAM's only master while busy.

---
 rtl/ram_bubble_sort_ctrl_pkg.sv | 26 ++
 rtl/ram_bubble_sort_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ram_bubble_sort_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sort_ctrl_pkg
// Shared types and constants for the RAM bubble-sort sequencer.
//   state_t          : sequencer states (3-bit encoding)
//   PAIR_CYC_NOSWAP  : cycles spent on one compared pair when no swap occurs
//   PAIR_CYC_SWAP    : cycles spent on one compared pair when it is swapped
// ---------------------------------------------------------------------------
package sort_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        CMP  = 3'd3,
        WR_A = 3'd4,
        WR_B = 3'd5,
        NEXT = 3'd6,
        DONE = 3'd7
    } state_t;

    // RD_A, RD_B, CMP, NEXT
    localparam int PAIR_CYC_NOSWAP = 4;
    // RD_A, RD_B, CMP, WR_A, WR_B, NEXT
    localparam int PAIR_CYC_SWAP   = 6;

endpackage

// File: rtl/ram_bubble_sort_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bubble_sort_ctrl
// In-place ascending (unsigned) bubble sort of RAM entries 0..len-1 through a
// single-port synchronous RAM with one cycle of read latency. A pass that
// makes no swap ends the sort early.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a sort (honoured only in IDLE)
//   len             : entries to sort, saturated to 2**ADDR_WDTH
//   busy            : sort in progress
//   done            : one-cycle completion pulse
//   ram_rd_enable   : RAM read strobe
//   ram_wr_enable   : RAM write strobe
//   ram_address     : RAM address (0 when neither strobe is high)
//   ram_wr_data     : RAM write data
//   ram_rd_data     : registered RAM read data
//   swap_cnt        : swaps made by the last sort (only with SORT_SWAP_CNT_EN)
//
// Build option: define SORT_SWAP_CNT_EN to add the swap_cnt output.
// ---------------------------------------------------------------------------
module ram_bubble_sort_ctrl
    import sort_ctrl_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WDTH:0]     len,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_rd_enable,
    output logic                   ram_wr_enable,
    output logic [ADDR_WDTH-1:0]   ram_address,
    output logic [DATA_WDTH-1:0]   ram_wr_data,
    input  logic [DATA_WDTH-1:0]   ram_rd_data
`ifdef SORT_SWAP_CNT_EN
    ,
    output logic [2*ADDR_WDTH:0]   swap_cnt
`endif
);

    localparam logic [ADDR_WDTH:0] MAX_LEN = {1'b1, {ADDR_WDTH{1'b0}}};
    localparam logic [ADDR_WDTH:0] ONE     = 1;
    localparam logic [ADDR_WDTH:0] TWO     = 2;

    state_t                 state, state_nxt;
    // Indices carry one extra bit so a full-depth sort never wraps.
    logic [ADDR_WDTH:0]     i, last;
    logic [DATA_WDTH-1:0]   reg_a, reg_b;
    logic                   swapped;

    logic [ADDR_WDTH:0]     len_eff;
    logic [ADDR_WDTH:0]     i_nxt;
    logic                   start_sort;
    logic                   pass_end;
    logic                   sort_end;

    assign len_eff    = (len > MAX_LEN) ? MAX_LEN : len;
    assign i_nxt      = i + ONE;
    assign start_sort = (state == IDLE) && start && (len_eff >= TWO);
    assign pass_end   = !(i_nxt < last);
    assign sort_end   = !swapped || (last == ONE);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        done          = 1'b0;
        ram_rd_enable = 1'b0;
        ram_wr_enable = 1'b0;
        ram_address   = '0;
        ram_wr_data   = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (len_eff >= TWO) ? RD_A : DONE;
            end
            RD_A: begin
                ram_rd_enable = 1'b1;
                ram_address   = i[ADDR_WDTH-1:0];
                state_nxt     = RD_B;
            end
            RD_B: begin
                ram_rd_enable = 1'b1;
                ram_address   = i_nxt[ADDR_WDTH-1:0];
                state_nxt     = CMP;
            end
            // Word i+1 is on ram_rd_data now; strict compare keeps equal
            // words in place, which makes the sort stable.
            CMP:  state_nxt = (reg_a > ram_rd_data) ? WR_A : NEXT;
            WR_A: begin
                ram_wr_enable = 1'b1;
                ram_address   = i[ADDR_WDTH-1:0];
                ram_wr_data   = reg_b;
                state_nxt     = WR_B;
            end
            WR_B: begin
                ram_wr_enable = 1'b1;
                ram_address   = i_nxt[ADDR_WDTH-1:0];
                ram_wr_data   = reg_a;
                state_nxt     = NEXT;
            end
            NEXT: state_nxt = (pass_end && sort_end) ? DONE : RD_A;
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= '0;
            last    <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            swapped <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start_sort) begin
                    last    <= len_eff - ONE;
                    i       <= '0;
                    swapped <= 1'b0;
                end
                RD_B: reg_a   <= ram_rd_data;
                CMP:  reg_b   <= ram_rd_data;
                WR_B: swapped <= 1'b1;
                NEXT: begin
                    if (!pass_end) begin
                        i <= i_nxt;
                    end else if (!sort_end) begin
                        // Largest remaining word has bubbled to 'last'.
                        last    <= last - ONE;
                        i       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SORT_SWAP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       swap_cnt <= '0;
        else if (state == IDLE && start)  swap_cnt <= '0;
        else if (state == WR_B)           swap_cnt <= swap_cnt + 1'b1;
    end
`else
    // No swap counter in this build.
`endif

endmodule
